// File: rtl/alphasoc_mem_ctrl.sv
// alphasoc_mem_ctrl: CPU valid/ready bus to single-port SRAM bridge with optional zero-fill after reset.
// Revision 1.0
`default_nettype none

module alphasoc_mem_ctrl #(
    parameter int          WORDS          = 256,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic [3:0]  ram_wen,
    output logic [21:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    output logic        init_done,
    output logic        addr_err
);

    typedef enum logic [2:0] {
        S_CLEAR   = 3'd0,
        S_IDLE    = 3'd1,
        S_ACCESS  = 3'd2,
        S_CAPTURE = 3'd3,
        S_RESP    = 3'd4,
        S_ERR     = 3'd5
    } state_t;

    localparam logic [33:0] LIMIT      = 34'(WORDS) << 2;
    localparam logic [21:0] LAST_WORD  = 22'(WORDS - 1);
    localparam state_t      RESET_STATE = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;

    state_t      state, state_n;
    logic [21:0] count, count_n;
    logic        wr, wr_n;
    logic        ready_n, done_n, err_n;
    logic [3:0]  wen_n;
    logic [21:0] addr_n;
    logic [31:0] wdata_n, rdata_n;

    logic [31:0] offset;
    logic        in_range;

    // Subtracting first keeps the upper bound check free of 32-bit overflow.
    assign offset   = mem_addr - BASE_ADDR;
    assign in_range = (mem_addr >= BASE_ADDR) && ({2'b00, offset} < LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RESET_STATE;
            count     <= '0;
            wr        <= 1'b0;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            ram_wen   <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            init_done <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            state     <= state_n;
            count     <= count_n;
            wr        <= wr_n;
            mem_ready <= ready_n;
            mem_rdata <= rdata_n;
            ram_wen   <= wen_n;
            ram_addr  <= addr_n;
            ram_wdata <= wdata_n;
            init_done <= done_n;
            addr_err  <= err_n;
        end
    end

    // Next values are computed one state ahead so the registered SRAM
    // controls line up with the cycle the state register names.
    always_comb begin
        state_n = state;
        count_n = count;
        wr_n    = wr;
        ready_n = 1'b0;
        rdata_n = mem_rdata;
        wen_n   = 4'h0;
        addr_n  = ram_addr;
        wdata_n = ram_wdata;
        done_n  = init_done;
        err_n   = addr_err;
        case (state)
            S_CLEAR: begin
                wen_n   = 4'hF;
                addr_n  = count;
                wdata_n = '0;
                count_n = count + 22'd1;
                if (count == LAST_WORD) begin
                    state_n = S_IDLE;
                end
            end
            S_IDLE: begin
                done_n = 1'b1;
                if (mem_valid) begin
                    if (in_range) begin
                        addr_n  = offset[23:2];
                        wdata_n = mem_wdata;
                        wen_n   = mem_wstrb;
                        wr_n    = (mem_wstrb != 4'h0);
                        state_n = S_ACCESS;
                    end else begin
                        state_n = S_ERR;
                    end
                end
            end
            S_ACCESS: begin
                if (wr) begin
                    ready_n = 1'b1;
                    state_n = S_RESP;
                end else begin
                    state_n = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                rdata_n = ram_rdata;
                ready_n = 1'b1;
                state_n = S_RESP;
            end
            S_ERR: begin
                rdata_n = '0;
                err_n   = 1'b1;
                ready_n = 1'b1;
                state_n = S_RESP;
            end
            S_RESP: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire
